prg_rom_responder: RTL and testbench

- Responder side of the CPU program-fetch interface: accepts a program image over a valid/ready load stream, holds the CPU in reset while loading, then returns instruction words (prg_data) for the CPU-driven pc.
- Sits between the program source (bench driver or boot loader) and the pipelined RISC-V core.
- Replaces bench-side modelling of prg_data and reset_n, so reset sequencing and fetch are synthesizable.

---
 rtl/prg_rom_pkg.sv | 17 +
 rtl/prg_rom_if.sv | 30 +++
 rtl/prg_rom_mem.sv | 40 ++++
 rtl/prg_rom_responder.sv | 149 ++++++++++++++
 tb/tb_prg_rom_responder.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/prg_rom_pkg.sv
// -----------------------------------------------------------------------------
// prg_rom_pkg
// Shared types and constants for the program-ROM responder.
//   WORD_W      : width of one instruction word
//   NOP_WORD    : word served on faulting fetches and outside RUN (addi x0,x0,0)
//   prg_state_e : responder FSM states (LOAD=0, HOLD=1, RUN=2)
// -----------------------------------------------------------------------------
package prg_rom_pkg;
   localparam int WORD_W = 32;
   localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0013;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      HOLD = 2'd1,
      RUN  = 2'd2
   } prg_state_e;
endpackage

// File: rtl/prg_rom_if.sv
// -----------------------------------------------------------------------------
// prg_rom_if
// Bundles the image load stream and the CPU fetch port of the responder.
//   ld_valid/ld_ready/ld_data/ld_last : program image load stream
//   pc                                : byte fetch address from the core
//   prg_data                          : instruction word returned to the core
// Modports:
//   master : program source / core side (drives load stream and pc)
//   slave  : responder side (drives ld_ready and prg_data)
// -----------------------------------------------------------------------------
interface prg_rom_if
   import prg_rom_pkg::*;
   ;
   logic              ld_valid;
   logic              ld_ready;
   logic [WORD_W-1:0] ld_data;
   logic              ld_last;
   logic [WORD_W-1:0] pc;
   logic [WORD_W-1:0] prg_data;

   modport master (
      output ld_valid, ld_data, ld_last, pc,
      input  ld_ready, prg_data
   );

   modport slave (
      input  ld_valid, ld_data, ld_last, pc,
      output ld_ready, prg_data
   );
endinterface

// File: rtl/prg_rom_mem.sv
// -----------------------------------------------------------------------------
// prg_rom_mem
// DEPTH x WORD_W simple dual-port synchronous RAM holding the program image.
// Contents are never cleared; a reset only restarts the load sequence.
// Ports:
//   clock     : write and read clock
//   i_wr_en   : write strobe (accepted load word)
//   i_wr_addr : write word index
//   i_wr_data : write data
//   i_rd_addr : read word index
//   o_rd_data : read data, one cycle after i_rd_addr
// -----------------------------------------------------------------------------
module prg_rom_mem
   import prg_rom_pkg::*;
#(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [WORD_W-1:0] i_wr_data,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [WORD_W-1:0] o_rd_data
);
   logic [WORD_W-1:0] r_mem [DEPTH];
   logic [WORD_W-1:0] r_rd_data;

   always_ff @(posedge clock) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   always_ff @(posedge clock) begin
      r_rd_data <= r_mem[i_rd_addr];
   end

   assign o_rd_data = r_rd_data;
endmodule

// File: rtl/prg_rom_responder.sv
// -----------------------------------------------------------------------------
// prg_rom_responder
// Responder side of the CPU program-fetch interface. Accepts a program image
// over a valid/ready stream, holds the core in reset while loading and for
// RESET_HOLD cycles afterwards, then serves instruction words for the pc the
// core presents, with one cycle of latency.
// Ports:
//   clock        : single clock, posedge
//   reset        : synchronous active-high reset
//   bus          : prg_rom_if.slave (load stream + pc/prg_data fetch port)
//   reload       : one-cycle pulse restarting the load sequence
//   cpu_reset_n  : active-low reset to the core (registered)
//   fault        : sticky misaligned / out-of-range fetch flag
//   loaded_words : number of words in the current image
//   state_o      : current FSM state (debug)
//   fetch_count  : count of non-faulting RUN fetches
// Configuration:
//   PRG_ROM_FETCH_COUNT_EN : when defined, fetch_count is a wrapping 32-bit
//                            counter; otherwise it is tied to zero.
// -----------------------------------------------------------------------------
module prg_rom_responder
   import prg_rom_pkg::*;
#(
   parameter int                DEPTH      = 256,
   parameter int                ADDR_W     = $clog2(DEPTH),
   parameter int                RESET_HOLD = 4,
   parameter logic [WORD_W-1:0] NOP_WORD   = prg_rom_pkg::NOP_WORD
) (
   input  logic            clock,
   input  logic            reset,
   prg_rom_if.slave        bus,
   input  logic            reload,
   output logic            cpu_reset_n,
   output logic            fault,
   output logic [ADDR_W:0] loaded_words,
   output logic [1:0]      state_o,
   output logic [31:0]     fetch_count
);
   localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

   prg_state_e        r_state;
   prg_state_e        w_state_next;
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W:0]   r_loaded_words;
   logic [HOLD_W-1:0] r_hold_cnt;
   logic              r_cpu_reset_n;
   logic              r_fault;
   logic              r_sel_nop;   // current prg_data comes from NOP_WORD, not RAM

   logic              w_ld_ready;
   logic              w_accept;
   logic              w_load_done;
   logic              w_hold_done;
   logic              w_run;
   logic              w_bad;
   logic [WORD_W-1:0] w_rd_data;

   assign w_ld_ready  = (r_state == LOAD) && !reset && !reload;
   assign w_accept    = bus.ld_valid && w_ld_ready;
   // An image fills at most DEPTH words; the last slot ends the load by itself.
   assign w_load_done = w_accept && (bus.ld_last || (r_wr_ptr == ADDR_W'(DEPTH - 1)));
   assign w_hold_done = (r_hold_cnt == HOLD_W'(RESET_HOLD - 1));
   assign w_run       = (r_state == RUN);
   // Full word index is compared so addresses beyond the RAM also fault.
   assign w_bad       = (bus.pc[1:0] != 2'b00) ||
                        (bus.pc[31:2] >= 30'(r_loaded_words));

   // ---------------- FSM ----------------
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= LOAD;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (reload) begin
         w_state_next = LOAD;
      end else begin
         unique case (r_state)
            LOAD:    if (w_load_done) w_state_next = HOLD;
            HOLD:    if (w_hold_done) w_state_next = RUN;
            RUN:     w_state_next = RUN;
            default: w_state_next = LOAD;
         endcase
      end
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clock) begin
      if (reset || reload) begin
         r_wr_ptr       <= '0;
         r_loaded_words <= '0;
         r_hold_cnt     <= '0;
         r_cpu_reset_n  <= 1'b0;
         r_fault        <= 1'b0;
         r_sel_nop      <= 1'b1;
      end else begin
         if (w_accept) begin
            r_wr_ptr       <= r_wr_ptr + ADDR_W'(1);
            r_loaded_words <= r_loaded_words + (ADDR_W + 1)'(1);
         end
         // Counter is only meaningful in HOLD; it is zero on HOLD entry.
         r_hold_cnt    <= (r_state == HOLD) ? r_hold_cnt + HOLD_W'(1) : '0;
         r_cpu_reset_n <= (w_state_next == RUN);
         r_fault       <= r_fault | (w_run && w_bad);
         r_sel_nop     <= !w_run || w_bad;
      end
   end

   prg_rom_mem #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clock     (clock),
      .i_wr_en   (w_accept),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (bus.ld_data),
      .i_rd_addr (bus.pc[ADDR_W+1:2]),
      .o_rd_data (w_rd_data)
   );

   // Both mux inputs are registered, so prg_data keeps its one-cycle latency.
   assign bus.prg_data = r_sel_nop ? NOP_WORD : w_rd_data;
   assign bus.ld_ready = w_ld_ready;

   assign cpu_reset_n  = r_cpu_reset_n;
   assign fault        = r_fault;
   assign loaded_words = r_loaded_words;
   assign state_o      = r_state;

`ifdef PRG_ROM_FETCH_COUNT_EN
   logic [31:0] r_fetch_count;

   always_ff @(posedge clock) begin
      if (reset || reload) begin
         r_fetch_count <= '0;
      end else if (w_run && !w_bad) begin
         r_fetch_count <= r_fetch_count + 32'd1;
      end
   end

   assign fetch_count = r_fetch_count;
`else
   assign fetch_count = '0;
`endif
endmodule

// File: tb/tb_prg_rom_responder.sv
// -----------------------------------------------------------------------------
// tb_prg_rom_responder
// Directed self-checking bench for prg_rom_responder: reset state, image load
// and hold sequencing, fetch, out-of-range and misaligned faults, full-depth
// image, reload priority and mid-load reset. Honours PRG_ROM_FETCH_COUNT_EN.
// -----------------------------------------------------------------------------
module tb_prg_rom_responder;
   import prg_rom_pkg::*;

   localparam int DEPTH  = 256;
   localparam int ADDR_W = 8;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic            clock = 1'b0;
   logic            reset;
   logic            reload;
   logic            cpu_reset_n;
   logic            fault;
   logic [ADDR_W:0] loaded_words;
   logic [1:0]      state_o;
   logic [31:0]     fetch_count;

   int checks = 0;
   int errors = 0;

   prg_rom_if bus_if ();

   prg_rom_responder #(
      .DEPTH      (DEPTH),
      .RESET_HOLD (4)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .bus          (bus_if),
      .reload       (reload),
      .cpu_reset_n  (cpu_reset_n),
      .fault        (fault),
      .loaded_words (loaded_words),
      .state_o      (state_o),
      .fetch_count  (fetch_count)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish before 200000");
      $fatal(1);
   end

   // ---------------- stimulus helpers (called at negedge) ----------------
   task automatic push(input logic [31:0] d, input logic last);
      bus_if.ld_valid = 1'b1;
      bus_if.ld_data  = d;
      bus_if.ld_last  = last;
      @(posedge clock);
      @(negedge clock);
      bus_if.ld_valid = 1'b0;
      bus_if.ld_last  = 1'b0;
      $display("load  data=%h last=%b loaded_words=%0d", d, last, loaded_words);
   endtask

   task automatic pulse_reload();
      reload = 1'b1;
      @(posedge clock);
      @(negedge clock);
      reload = 1'b0;
   endtask

   task automatic fetch(input logic [31:0] a);
      bus_if.pc = a;
      @(posedge clock);
      @(negedge clock);
      $display("fetch pc=%h prg_data=%h fault=%b", a, bus_if.prg_data, fault);
   endtask

   task automatic wait_run();
      int n = 0;
      while (cpu_reset_n !== 1'b1 && n < 20) begin
         @(posedge clock);
         @(negedge clock);
         n++;
      end
      checks++;
      if (cpu_reset_n !== 1'b1) begin
         errors++;
         $display("FAIL wait_run: cpu_reset_n=%b after %0d cycles, required 1", cpu_reset_n, n);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1; reload = 1'b0;
      bus_if.ld_valid = 1'b0; bus_if.ld_data = '0; bus_if.ld_last = 1'b0; bus_if.pc = '0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      checks++; if (cpu_reset_n !== 1'b0) begin errors++; $display("FAIL rst_cpu_reset_n: got %b, required 0", cpu_reset_n); end
      checks++; if (bus_if.prg_data !== NOP) begin errors++; $display("FAIL rst_prg_data: got %h, required %h", bus_if.prg_data, NOP); end
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL rst_fault: got %b, required 0", fault); end
      checks++; if (loaded_words !== '0) begin errors++; $display("FAIL rst_loaded_words: got %0d, required 0", loaded_words); end
      checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d, required 0", state_o); end
      checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL rst_fetch_count: got %0d, required 0", fetch_count); end
      checks++; if (bus_if.ld_ready !== 1'b0) begin errors++; $display("FAIL rst_ld_ready_in_reset: got %b, required 0", bus_if.ld_ready); end
      reset = 1'b0;
      #1;
      checks++; if (bus_if.ld_ready !== 1'b1) begin errors++; $display("FAIL rst_ld_ready: got %b, required 1", bus_if.ld_ready); end
      $display("reset done");
   endtask

   task automatic test_load_fetch();
      push(32'h11, 1'b0);
      push(32'h22, 1'b0);
      push(32'h33, 1'b0);
      push(32'h44, 1'b1);
      checks++; if (loaded_words !== 9'd4) begin errors++; $display("FAIL lf_loaded_words: got %0d, required 4", loaded_words); end
      checks++; if (bus_if.ld_ready !== 1'b0) begin errors++; $display("FAIL lf_ld_ready: got %b, required 0", bus_if.ld_ready); end
      checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL lf_state_hold: got %0d, required 1", state_o); end
      // Accept cycle is cycle 0; cpu_reset_n must first read 1 in cycle 5.
      for (int k = 1; k <= 4; k++) begin
         @(posedge clock);
         @(negedge clock);
         checks++;
         if (cpu_reset_n !== (k == 4)) begin
            errors++;
            $display("FAIL lf_cpu_reset_n_c%0d: got %b, required %b", k + 1, cpu_reset_n, (k == 4));
         end
      end
      checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL lf_state_run: got %0d, required 2", state_o); end
      fetch(32'h8);
      checks++; if (bus_if.prg_data !== 32'h33) begin errors++; $display("FAIL lf_fetch8: got %h, required 00000033", bus_if.prg_data); end
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL lf_fault: got %b, required 0", fault); end
   endtask

   task automatic test_out_of_range();
      fetch(32'h10);
      checks++; if (bus_if.prg_data !== NOP) begin errors++; $display("FAIL oor_data: got %h, required %h", bus_if.prg_data, NOP); end
      checks++; if (fault !== 1'b1) begin errors++; $display("FAIL oor_fault: got %b, required 1", fault); end
      fetch(32'h0);
      checks++; if (bus_if.prg_data !== 32'h11) begin errors++; $display("FAIL oor_recover: got %h, required 00000011", bus_if.prg_data); end
      checks++; if (fault !== 1'b1) begin errors++; $display("FAIL oor_sticky: got %b, required 1", fault); end
   endtask

   task automatic test_misaligned();
      bus_if.pc = 32'h0;
      pulse_reload();
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL mis_fault_clear: got %b, required 0", fault); end
      push(32'hA1, 1'b0);
      push(32'hA2, 1'b0);
      push(32'hA3, 1'b0);
      push(32'hA4, 1'b1);
      wait_run();
      fetch(32'h4);
      checks++; if (bus_if.prg_data !== 32'hA2) begin errors++; $display("FAIL mis_fetch4: got %h, required 000000a2", bus_if.prg_data); end
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL mis_no_fault: got %b, required 0", fault); end
      fetch(32'h6);
      checks++; if (bus_if.prg_data !== NOP) begin errors++; $display("FAIL mis_data: got %h, required %h", bus_if.prg_data, NOP); end
      checks++; if (fault !== 1'b1) begin errors++; $display("FAIL mis_fault: got %b, required 1", fault); end
   endtask

   task automatic test_full_depth();
      bus_if.pc = 32'h0;
      pulse_reload();
      for (int i = 0; i < DEPTH; i++) begin
         push(32'hC000_0000 + i, 1'b0);
      end
      checks++; if (loaded_words !== 9'(DEPTH)) begin errors++; $display("FAIL fd_loaded_words: got %0d, required %0d", loaded_words, DEPTH); end
      checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL fd_state_hold: got %0d, required 1", state_o); end
      checks++; if (bus_if.ld_ready !== 1'b0) begin errors++; $display("FAIL fd_ld_ready: got %b, required 0", bus_if.ld_ready); end
      wait_run();
      fetch(32'(4 * (DEPTH - 1)));
      checks++; if (bus_if.prg_data !== 32'hC000_00FF) begin errors++; $display("FAIL fd_last_word: got %h, required c00000ff", bus_if.prg_data); end
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL fd_fault: got %b, required 0", fault); end
      fetch(32'h0);
      checks++; if (bus_if.prg_data !== 32'hC000_0000) begin errors++; $display("FAIL fd_first_word: got %h, required c0000000", bus_if.prg_data); end
   endtask

   task automatic test_reload();
      fetch(32'h400);
      checks++; if (fault !== 1'b1) begin errors++; $display("FAIL rl_pre_fault: got %b, required 1", fault); end
      reload = 1'b1;
      bus_if.ld_valid = 1'b1; bus_if.ld_data = 32'hDEAD_BEEF; bus_if.ld_last = 1'b1;
      @(posedge clock);
      @(negedge clock);
      reload = 1'b0;
      bus_if.ld_valid = 1'b0; bus_if.ld_last = 1'b0;
      $display("reload with same-cycle load word deadbeef");
      checks++; if (cpu_reset_n !== 1'b0) begin errors++; $display("FAIL rl_cpu_reset_n: got %b, required 0", cpu_reset_n); end
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL rl_fault: got %b, required 0", fault); end
      checks++; if (loaded_words !== '0) begin errors++; $display("FAIL rl_loaded_words: got %0d, required 0", loaded_words); end
      checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL rl_state: got %0d, required 0", state_o); end
      checks++; if (bus_if.prg_data !== NOP) begin errors++; $display("FAIL rl_prg_data: got %h, required %h", bus_if.prg_data, NOP); end
      bus_if.pc = 32'h0;
      push(32'h55, 1'b0);
      push(32'h66, 1'b1);
      checks++; if (loaded_words !== 9'd2) begin errors++; $display("FAIL rl_new_count: got %0d, required 2", loaded_words); end
      wait_run();
      fetch(32'h4);
      checks++; if (bus_if.prg_data !== 32'h66) begin errors++; $display("FAIL rl_fetch4: got %h, required 00000066", bus_if.prg_data); end
      fetch(32'h0);
      checks++; if (bus_if.prg_data !== 32'h55) begin errors++; $display("FAIL rl_fetch0: got %h, required 00000055", bus_if.prg_data); end
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL rl_no_fault: got %b, required 0", fault); end
   endtask

   task automatic test_reset_mid_load();
      logic [31:0] exp_cnt;
      bus_if.pc = 32'h0;
      pulse_reload();
      push(32'h1, 1'b0);
      push(32'h2, 1'b0);
      checks++; if (loaded_words !== 9'd2) begin errors++; $display("FAIL rml_partial: got %0d, required 2", loaded_words); end
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      #1;
      checks++; if (loaded_words !== '0) begin errors++; $display("FAIL rml_loaded_words: got %0d, required 0", loaded_words); end
      checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL rml_state: got %0d, required 0", state_o); end
      checks++; if (bus_if.ld_ready !== 1'b1) begin errors++; $display("FAIL rml_ld_ready: got %b, required 1", bus_if.ld_ready); end
      checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL rml_fetch_count_rst: got %0d, required 0", fetch_count); end
      @(negedge clock);
      push(32'h71, 1'b0);
      push(32'h72, 1'b0);
      push(32'h73, 1'b0);
      push(32'h74, 1'b1);
      wait_run();
      checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL rml_fetch_count_entry: got %0d, required 0", fetch_count); end
      for (int k = 0; k < 3; k++) fetch(32'h0);
`ifdef PRG_ROM_FETCH_COUNT_EN
      exp_cnt = 32'd3;
`else
      exp_cnt = 32'd0;
`endif
      checks++; if (fetch_count !== exp_cnt) begin errors++; $display("FAIL rml_fetch_count: got %0d, required %0d", fetch_count, exp_cnt); end
      checks++; if (bus_if.prg_data !== 32'h71) begin errors++; $display("FAIL rml_fetch0: got %h, required 00000071", bus_if.prg_data); end
   endtask

   initial begin
      test_reset();
      test_load_fetch();
      test_out_of_range();
      test_misaligned();
      test_full_depth();
      test_reload();
      test_reset_mid_load();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
